// File: rtl/smpl_queue_pkg.sv
// Shared constants, state encoding and pointer helper for the stereo sample ring
// and the band FIR stages that consume its replay bursts.
package smpl_queue_pkg;

  localparam int DEPTH_B1  = 1021;  // FIR tap count; coefficient address also wraps here
  localparam int ADDR_W_B1 = 10;
  localparam int SMPL_W    = 16;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    IDLE = 2'd1,
    READ = 2'd2
  } state_e;

  // Ring depth is not a power of two, so wrap by compare rather than masking.
  function automatic int wrap_inc(int ptr, int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/smpl_queue_if.sv
// Sample-in / replay-out bundle between the sample source, the ring and the FIR.
interface smpl_queue_if import smpl_queue_pkg::*; ();

  logic                     wrt_smpl;
  logic signed [SMPL_W-1:0] lft_smpl;
  logic signed [SMPL_W-1:0] rht_smpl;
  logic signed [SMPL_W-1:0] lft_out;
  logic signed [SMPL_W-1:0] rht_out;
  logic                     sequencing;
  logic                     ovr;

  modport master (
    output wrt_smpl, lft_smpl, rht_smpl,
    input  lft_out, rht_out, sequencing, ovr
  );

  modport slave (
    input  wrt_smpl, lft_smpl, rht_smpl,
    output lft_out, rht_out, sequencing, ovr
  );

endinterface

// File: rtl/smpl_queue_dualport_ram.sv
// Simple dual-port RAM: one write port, one read port with registered read data.
module smpl_queue_dualport_ram #(
  parameter int DEPTH  = 1021,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/smpl_queue.sv
// Circular stereo sample ring: once full, every new sample triggers a replay of
// all DEPTH stored samples, oldest first, one per clock with sequencing high.
module smpl_queue import smpl_queue_pkg::*; #(
  parameter int DEPTH  = DEPTH_B1,
  parameter int ADDR_W = ADDR_W_B1
) (
  input  logic         clk,
  input  logic         rst_n,
  smpl_queue_if.slave  q_if
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] LAST_C  = DEPTH_C - ONE_C;

  state_e                   state_q, state_d;
  logic [ADDR_W-1:0]        new_ptr_q, new_ptr_d;
  logic [ADDR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]          cnt_q, cnt_d;
  logic [ADDR_W:0]          rd_cnt_q, rd_cnt_d;
  logic                     ovr_q, ovr_d;
  logic                     vld_p1_q;
  logic                     sequencing_q;
  logic signed [SMPL_W-1:0] lft_out_q, rht_out_q;
  logic                     we;
  logic [2*SMPL_W-1:0]      rdata;

  function automatic logic [ADDR_W-1:0] ptr_inc(logic [ADDR_W-1:0] p);
    return ADDR_W'(wrap_inc(int'(p), DEPTH));
  endfunction

  smpl_queue_dualport_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (2*SMPL_W)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (new_ptr_q),
    .wdata ({q_if.lft_smpl, q_if.rht_smpl}),
    .raddr (rd_ptr_q),
    .rdata (rdata)
  );

  always_comb begin
    state_d   = state_q;
    new_ptr_d = new_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    rd_cnt_d  = rd_cnt_q;
    ovr_d     = 1'b0;
    we        = 1'b0;
    case (state_q)
      FILL, IDLE: begin
        if (q_if.wrt_smpl) begin
          we        = 1'b1;
          new_ptr_d = ptr_inc(new_ptr_q);
          if (cnt_q != DEPTH_C) cnt_d = cnt_q + ONE_C;
          // After the write, new_ptr points at the oldest sample: burst starts there.
          rd_ptr_d  = new_ptr_d;
          rd_cnt_d  = '0;
          if (state_q == IDLE || (cnt_q + ONE_C) == DEPTH_C) state_d = READ;
        end
      end
      READ: begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
        rd_cnt_d = rd_cnt_q + ONE_C;
        ovr_d    = q_if.wrt_smpl;
        if (rd_cnt_q == LAST_C) state_d = IDLE;
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FILL;
      new_ptr_q    <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      rd_cnt_q     <= '0;
      ovr_q        <= 1'b0;
      vld_p1_q     <= 1'b0;
      sequencing_q <= 1'b0;
      lft_out_q    <= '0;
      rht_out_q    <= '0;
    end else begin
      state_q      <= state_d;
      new_ptr_q    <= new_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      ovr_q        <= ovr_d;
      // RAM read data lands one clock after the address; outputs one more.
      vld_p1_q     <= (state_q == READ);
      sequencing_q <= vld_p1_q;
      if (vld_p1_q) begin
        lft_out_q <= $signed(rdata[2*SMPL_W-1:SMPL_W]);
        rht_out_q <= $signed(rdata[SMPL_W-1:0]);
      end
    end
  end

  assign q_if.lft_out    = lft_out_q;
  assign q_if.rht_out    = rht_out_q;
  assign q_if.sequencing = sequencing_q;
  assign q_if.ovr        = ovr_q;

endmodule

// File: tb/tb_smpl_queue.sv
// Scoreboard bench for smpl_queue: a DEPTH=8 instance for the directed cases and
// a default-depth instance for the full-scale burst.
module tb_smpl_queue;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  smpl_queue_if if8();
  smpl_queue_if if1k();

  smpl_queue #(.DEPTH(8), .ADDR_W(3)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .q_if  (if8)
  );

  smpl_queue #(.DEPTH(1021), .ADDR_W(10)) dut1k (
    .clk   (clk),
    .rst_n (rst_n),
    .q_if  (if1k)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int run = 0;
  int seq_cyc = 0;
  int ovr_cnt = 0;
  logic [31:0] exp_q[$];
  int start_q[$];
  int len_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Monitor: pops the scoreboard whenever either instance presents a sample.
  always @(negedge clk) begin
    logic [31:0] act;
    if (!rst_n) begin
      run = 0;
    end else begin
      if (if8.ovr || if1k.ovr) ovr_cnt++;
      if (if8.sequencing && if1k.sequencing) check("both_sequencing", 1, 0);
      if (if8.sequencing || if1k.sequencing) begin
        seq_cyc++;
        act = if8.sequencing ? {if8.lft_out, if8.rht_out} : {if1k.lft_out, if1k.rht_out};
        if (run == 0) begin
          if (start_q.size() == 0) check("unexpected_burst", cyc, 0);
          else check("burst_start_cycle", cyc, start_q.pop_front());
        end
        run++;
        if (exp_q.size() == 0) check("unexpected_sample", act, 32'hxxxx_xxxx);
        else check("sample", act, exp_q.pop_front());
      end else if (run != 0) begin
        if (len_q.size() == 0) check("unexpected_burst_len", run, 0);
        else check("burst_len", run, len_q.pop_front());
        run = 0;
      end
    end
  end

  task automatic wr(input bit big, input logic [15:0] l, input logic [15:0] r, output int c);
    @(posedge clk); #1;
    if (big) begin
      if1k.wrt_smpl = 1'b1; if1k.lft_smpl = l; if1k.rht_smpl = r;
    end else begin
      if8.wrt_smpl = 1'b1; if8.lft_smpl = l; if8.rht_smpl = r;
    end
    c = cyc;
    @(posedge clk); #1;
    if8.wrt_smpl  = 1'b0;
    if1k.wrt_smpl = 1'b0;
  endtask

  // Burst of L=first..first+7 with R=-L, rising 3 counted cycles after the drive.
  task automatic expect8(input int first, input int c);
    for (int k = 0; k < 8; k++) exp_q.push_back({16'(first + k), 16'(-(first + k))});
    len_q.push_back(8);
    start_q.push_back(c + 3);
  endtask

  task automatic wait_done(input int max);
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && len_q.size() == 0) break;
    end
    check("burst_drained", 32'(exp_q.size() + len_q.size()), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, c2, s0, o0;
    logic [15:0] l;
    if8.wrt_smpl = 1'b0;  if8.lft_smpl = '0;  if8.rht_smpl = '0;
    if1k.wrt_smpl = 1'b0; if1k.lft_smpl = '0; if1k.rht_smpl = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_seq8", if8.sequencing, 0);
    check("rst_ovr8", if8.ovr, 0);
    check("rst_lft8", if8.lft_out, 0);
    check("rst_rht8", if8.rht_out, 0);
    check("rst_seq1k", if1k.sequencing, 0);
    check("rst_ovr1k", if1k.ovr, 0);
    rst_n = 1'b1;

    // Samples 1..7: ring not yet full.
    s0 = seq_cyc; o0 = ovr_cnt;
    for (int i = 1; i <= 7; i++) wr(1'b0, 16'(i), 16'(-i), c);
    repeat (15) @(posedge clk);
    check("fill_no_seq", seq_cyc - s0, 0);
    check("fill_no_ovr", ovr_cnt - o0, 0);

    wr(1'b0, 16'd8, -16'sd8, c);
    expect8(1, c);
    wait_done(40);

    wr(1'b0, 16'd9, -16'sd9, c);
    expect8(2, c);
    repeat (20) @(posedge clk);
    wait_done(40);

    // Sample 10 crosses the 7->0 pointer wrap; 99 arrives mid-burst and is dropped.
    o0 = ovr_cnt;
    wr(1'b0, 16'd10, -16'sd10, c);
    expect8(3, c);
    repeat (2) @(posedge clk);
    wr(1'b0, 16'd99, -16'sd99, c2);
    wait_done(40);
    check("ovr_pulse_count", ovr_cnt - o0, 1);

    wr(1'b0, 16'd11, -16'sd11, c);
    expect8(4, c);
    wait_done(40);

    // Asynchronous reset in the middle of the 5..12 burst.
    wr(1'b0, 16'd12, -16'sd12, c);
    expect8(5, c);
    repeat (3) @(posedge clk);
    #3;
    check("seq_before_rst", if8.sequencing, 1);
    rst_n = 1'b0;
    #1;
    check("seq_async_drop", if8.sequencing, 0);
    check("lft_async_clear", if8.lft_out, 0);
    exp_q.delete(); len_q.delete(); start_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    s0 = seq_cyc;
    for (int i = 21; i <= 27; i++) wr(1'b0, 16'(i), 16'(-i), c);
    repeat (15) @(posedge clk);
    check("refill_no_seq", seq_cyc - s0, 0);
    wr(1'b0, 16'd28, -16'sd28, c);
    expect8(21, c);
    wait_done(40);

    // Full-depth instance: full-scale extremes, alternating so ordering is visible.
    s0 = seq_cyc;
    for (int i = 0; i < 1021; i++) begin
      l = i[0] ? 16'h8000 : 16'h7FFF;
      wr(1'b1, l, ~l, c);
    end
    for (int i = 0; i < 1021; i++) begin
      l = i[0] ? 16'h8000 : 16'h7FFF;
      exp_q.push_back({l, ~l});
    end
    len_q.push_back(1021);
    start_q.push_back(c + 3);
    wait_done(1100);
    check("big_seq_cycles", seq_cyc - s0, 1021);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/smpl_queue.md
Name: smpl_queue

Overview:
Circular stereo sample buffer sitting directly upstream of the band FIR stages in the audio equalizer path. It stores incoming left/right 16-bit samples in a DEPTH-entry ring. Once the ring is full, every new sample triggers one read burst. The burst replays all DEPTH stored samples, oldest to newest, on consecutive clocks. It raises `sequencing` so that the downstream FIR accumulates one coefficient·sample product per clock.

Parameters:
DEPTH, 1021, ring entries = FIR tap count; the FIR coefficient address wraps at 0x3FD.
ADDR_W, 10, pointer width; must satisfy 2^ADDR_W >= DEPTH.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
wrt_smpl  in  1  one-cycle pulse: lft_smpl/rht_smpl are valid this cycle
lft_smpl  in  16  signed left input sample
rht_smpl  in  16  signed right input sample
lft_out  out  16  signed left sample being replayed (valid while sequencing=1)
rht_out  out  16  signed right sample being replayed (valid while sequencing=1)
sequencing  out  1  high for exactly DEPTH consecutive cycles per burst
ovr  out  1  one-cycle pulse: wrt_smpl arrived during a burst and was dropped

Behaviour:
- Reset:
  - One clock (clk); reset is asynchronous and active-low (rst_n).
  - While rst_n=0: new_ptr=0, cnt=0, state=FILL, sequencing=0, ovr=0, lft_out=rht_out=0.
  - Assertion mid-burst ends it immediately; all stored history is treated as empty.
- States: FILL, IDLE, READ.
- Write, in FILL or IDLE, at edge E0 with wrt_smpl=1:
  - {lft_smpl,rht_smpl} is written at new_ptr.
  - new_ptr <= (new_ptr+1) wraps DEPTH-1 -> 0.
  - cnt <= min(cnt+1, DEPTH).
  - When full, the write overwrites the oldest entry; new_ptr then points at the oldest sample.
- FILL -> READ: at E0 when cnt+1 == DEPTH; the first burst happens on the DEPTH-th sample.
- IDLE -> READ: at every E0.
- Burst start: at E0, rd_ptr <= new_ptr after increment (the oldest sample).
- In READ:
  - The RAM read address is rd_ptr; rd_ptr increments with wrap each cycle.
  - After DEPTH addresses have been issued, the state moves to IDLE.
- Read latency: the RAM has a 1-cycle synchronous read. Outputs are registered, so sequencing and data are aligned.
  - sequencing rises at edge E0+2 and falls at edge E0+DEPTH+2, i.e. high for exactly DEPTH cycles.
  - The first output is the oldest sample. The last output is the sample written at E0.
- Outputs outside a burst: lft_out/rht_out hold their last value; downstream must qualify them with sequencing.
- wrt_smpl in READ (protocol violation): the sample is not written, pointers and cnt are unchanged, ovr=1 for one cycle. The burst completes unaltered.
- wrt_smpl in the same cycle as the last burst address: still READ, so it is dropped with ovr.
- Timing budget: a burst occupies DEPTH+2 cycles. At 50 MHz clk and 48 kHz audio (~1041 cycles/sample) this fits with DEPTH=1021.
- No arithmetic on data: samples pass bit-exact. Pointer wrap uses compare-to-DEPTH-1, not power-of-2 masking.

Decomposition:
- Shared include eq_defs.vh:
  - DEPTH_B1 = 1021.
  - ADDR_W = 10.
  - State encodings FILL/IDLE/READ.
  - The same DEPTH constant is used by the FIR coefficient wrap.
- Sub-module dualport_ram:
  - DEPTH x 32 storage.
  - One write port (we, waddr, wdata).
  - One read port (raddr) with registered rdata.
  - Inferable as block RAM.
- smpl_queue holds the pointers, cnt, FSM, and output alignment registers.

Test Plan:
- DEPTH=8 (bench-scale). Write samples 1..7 on L (R = -L) -> sequencing never asserts; ovr=0.
- DEPTH=8. Write the 8th sample -> sequencing high exactly 8 cycles starting 2 cycles after the pulse; L out 1,2,...,8 and R out -1..-8.
- DEPTH=8, full ring. Write samples 9 and 10, spaced 20 cycles apart -> bursts 2..9 and 3..10 (wrap of new_ptr through 7->0 verified).
- DEPTH=8. Pulse wrt_smpl (value 99) 3 cycles into a burst -> ovr pulses once; burst unchanged. The next burst after a legal write of 11 is 4..11, with 99 absent.
- DEPTH=8. Deassert rst_n asynchronously mid-burst -> sequencing drops to 0 without a clock edge. The 8 new samples after release are needed before the next burst.
- DEPTH=1021 default. Write 1021 samples of 0x7FFF/0x8000 -> sequencing high exactly 1021 cycles; outputs bit-exact.
